// File: rtl/core_noc_arbiter_pkg.sv
// Shared types for the core NOC arbiter: packet layout, port status,
// TX/RX FSM state encodings and requester limits.
package core_noc_arbiter_pkg;

  localparam int NOC_ARB_MAX_REQ = 4;
  localparam int NOC_ARB_IDX_W   = 2;

  typedef enum logic [1:0] {
    memory_read_request  = 2'd0,
    memory_write_request = 2'd1,
    memory_read_reply    = 2'd2,
    memory_write_ack     = 2'd3
  } pkt_type_t;

  typedef enum logic [1:0] {
    port_closed = 2'd0,
    port_open   = 2'd1,
    port_busy   = 2'd2
  } port_stat_t;

  typedef struct packed {
    pkt_type_t                pkt_type;
    logic [7:0]               dst_addr;
    logic [1:0]               dst_prt;
    logic [7:0]               src_addr;
    logic [1:0]               src_prt;
    logic [NOC_ARB_IDX_W-1:0] id;
    logic [15:0]              data;
  } packet_t;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_BUSY = 1'b1
  } tx_state_t;

  typedef enum logic {
    RX_IDLE    = 1'b0,
    RX_DELIVER = 1'b1
  } rx_state_t;

  // Outgoing packets carry this core's address/port and the granted index as id,
  // so the reply can be routed back to the right requester.
  function automatic packet_t stamp_tx(input packet_t p, input logic [7:0] addr,
                                       input logic [1:0] prt,
                                       input logic [NOC_ARB_IDX_W-1:0] idx);
    packet_t s;
    s          = p;
    s.src_addr = addr;
    s.src_prt  = prt;
    s.id       = idx;
    return s;
  endfunction

endpackage

// File: rtl/ip_port.sv
// Core-side NOC port bundle. The core drives dat_to_noc/tx_submit/rx_complete;
// the network drives everything else.
interface ip_port;
  import core_noc_arbiter_pkg::*;

  packet_t    dat_to_noc;
  logic       tx_submit;
  logic       tx_complete;
  port_stat_t to_noc_prt_stat;
  logic       rx_recieve;
  packet_t    dat_from_noc;
  logic       rx_complete;
  logic [7:0] port_address;
  logic [1:0] port_number;

  modport core (
    output dat_to_noc, tx_submit, rx_complete,
    input  tx_complete, to_noc_prt_stat, rx_recieve, dat_from_noc,
           port_address, port_number
  );

  modport noc (
    input  dat_to_noc, tx_submit, rx_complete,
    output tx_complete, to_noc_prt_stat, rx_recieve, dat_from_noc,
           port_address, port_number
  );

endinterface

// File: rtl/core_noc_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the lowest requester at or above ptr wins,
// otherwise the lowest requester below ptr (wrap-around).
module rr_arbiter
  import core_noc_arbiter_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]             req,
  input  logic [NOC_ARB_IDX_W-1:0] ptr,
  output logic [N-1:0]             gnt,
  output logic [NOC_ARB_IDX_W-1:0] idx
);

  // Two descending scans: the second (indices >= ptr) overrides the first.
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (req[j] && (j < int'(ptr))) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = NOC_ARB_IDX_W'(j);
      end
    end
    for (int j = N - 1; j >= 0; j--) begin
      if (req[j] && (j >= int'(ptr))) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = NOC_ARB_IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/core_noc_arbiter.sv
// Shares one NOC port between NUM_REQ requesters.
// TX: round-robin grant, packet presented until the NOC accepts it.
// RX: reply captured, routed by id to one requester, released on rsp_done.
// Optional grant timeout selected by NOC_ARB_TIMEOUT_EN.
//
// Handshakes: a transfer completes in the cycle where the holder's valid
// (tx_submit / rsp_valid / rx_recieve) and the consumer's acknowledge
// (tx_complete with port_open / rsp_done[target] / RX_IDLE capture) are
// both high at posedge clk; the completion pulse (req_tx_done / rx_complete)
// is combinational in that same cycle.
module core_noc_arbiter
  import core_noc_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int TMO_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_submit,
  input  packet_t [NUM_REQ-1:0] req_pkt,
  output logic [NUM_REQ-1:0]    req_tx_done,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output packet_t               rsp_pkt,
  input  logic [NUM_REQ-1:0]    rsp_done,
  ip_port.core                  noc_port,
  output logic                  tmo_err,
  output tx_state_t             dbg_tx_state,
  output rx_state_t             dbg_rx_state
);

  tx_state_t                tx_state, tx_state_n;
  rx_state_t                rx_state, rx_state_n;
  logic [NUM_REQ-1:0]       arb_gnt, grant_oh_q, tgt_oh;
  logic [NOC_ARB_IDX_W-1:0] arb_idx, grant_idx_q, rr_ptr_q, rx_target_q;
  packet_t                  sel_pkt, rx_pkt_in, rsp_pkt_q, dat_to_noc_c;
  logic                     tx_accept, tmo_hit, tx_submit_c, rx_complete_c;
  logic                     rx_in_range, done_hit;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req (req_submit),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  assign tx_accept   = (tx_state == TX_BUSY) && noc_port.tx_complete &&
                       (noc_port.to_noc_prt_stat == port_open);
  assign rx_pkt_in   = noc_port.dat_from_noc;
  assign rx_in_range = int'(rx_pkt_in.id) < NUM_REQ;
  assign done_hit    = |(rsp_done & tgt_oh);

  // Mux the granted requester's packet and decode the reply target one-hot.
  always_comb begin
    sel_pkt = '0;
    tgt_oh  = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (int'(grant_idx_q) == j) sel_pkt = req_pkt[j];
      tgt_oh[j] = (int'(rx_target_q) == j);
    end
  end

  // TX next state and outputs; completion pulses are masked while in reset.
  always_comb begin
    tx_state_n   = tx_state;
    tx_submit_c  = 1'b0;
    dat_to_noc_c = '0;
    req_tx_done  = '0;
    case (tx_state)
      TX_IDLE: if (|req_submit) tx_state_n = TX_BUSY;
      TX_BUSY: begin
        tx_submit_c  = !rst;
        dat_to_noc_c = stamp_tx(sel_pkt, noc_port.port_address,
                                noc_port.port_number, grant_idx_q);
        if (tx_accept) begin
          req_tx_done = rst ? '0 : grant_oh_q;
          tx_state_n  = TX_IDLE;
        end else if (tmo_hit) begin
          tx_state_n  = TX_IDLE;
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  // TX state, grant capture and round-robin pointer (advanced past each grant).
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state    <= TX_IDLE;
      grant_idx_q <= '0;
      grant_oh_q  <= '0;
      rr_ptr_q    <= '0;
    end else begin
      tx_state <= tx_state_n;
      if ((tx_state == TX_IDLE) && (|req_submit)) begin
        grant_idx_q <= arb_idx;
        grant_oh_q  <= arb_gnt;
        rr_ptr_q    <= (int'(arb_idx) == NUM_REQ - 1) ? '0 : arb_idx + 2'd1;
      end
    end
  end

  // RX next state and outputs; out-of-range ids are acknowledged and dropped.
  always_comb begin
    rx_state_n    = rx_state;
    rx_complete_c = 1'b0;
    rsp_valid     = '0;
    case (rx_state)
      RX_IDLE: begin
        if (noc_port.rx_recieve) begin
          if (rx_in_range) rx_state_n    = RX_DELIVER;
          else             rx_complete_c = !rst;
        end
      end
      RX_DELIVER: begin
        rsp_valid = rst ? '0 : tgt_oh;
        if (done_hit) begin
          rx_complete_c = !rst;
          rx_state_n    = RX_IDLE;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // RX state and reply capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state    <= RX_IDLE;
      rx_target_q <= '0;
      rsp_pkt_q   <= '0;
    end else begin
      rx_state <= rx_state_n;
      if ((rx_state == RX_IDLE) && noc_port.rx_recieve && rx_in_range) begin
        rsp_pkt_q   <= rx_pkt_in;
        rx_target_q <= rx_pkt_in.id;
      end
    end
  end

`ifdef NOC_ARB_TIMEOUT_EN
  logic [7:0] tmo_cnt;
  logic       tmo_err_q;

  // Fires on the TMO_CYCLES-th busy cycle; a completion in that cycle wins.
  assign tmo_hit = (tx_state == TX_BUSY) && !tx_accept &&
                   (tmo_cnt == 8'(TMO_CYCLES - 1));
  assign tmo_err = tmo_err_q && !rst;

  // Busy-cycle counter (held at zero while idle) and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt   <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      tmo_cnt <= (tx_state == TX_BUSY) ? tmo_cnt + 8'd1 : 8'd0;
      if (tmo_hit) tmo_err_q <= 1'b1;
    end
  end
`else
  logic unused_tmo_cycles;
  assign unused_tmo_cycles = ^TMO_CYCLES;
  assign tmo_hit           = 1'b0;
  assign tmo_err           = 1'b0;
`endif

  assign noc_port.tx_submit   = tx_submit_c;
  assign noc_port.dat_to_noc  = dat_to_noc_c;
  assign noc_port.rx_complete = rx_complete_c;
  assign rsp_pkt              = rst ? '0 : rsp_pkt_q;
  assign dbg_tx_state         = tx_state;
  assign dbg_rx_state         = rx_state;

endmodule

// File: doc/core_noc_arbiter.md
CORE_NOC_ARBITER -- requirements
Module: core_noc_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2: number of requesters (2..4).
REQ-002 SHALL have parameter TMO_CYCLES, default 255: tx-grant timeout limit, used only under REQ-030.
REQ-003 clk  in  1  core clock; single clock domain; all state updates on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 req_submit  in  NUM_REQ  per-requester tx request, held until req_tx_done.
REQ-006 req_pkt  in  NUM_REQ x packet  per-requester tx packet.
REQ-007 req_tx_done  out  NUM_REQ  one-cycle pulse: packet accepted by NOC.
REQ-008 rsp_valid  out  NUM_REQ  reply waiting for that requester.
REQ-009 rsp_pkt  out  packet  reply packet, shared bus, valid where rsp_valid set.
REQ-010 rsp_done  in  NUM_REQ  requester consumed reply.
REQ-011 noc_port  inout  ip_port  the core's single NOC port (dat_to_noc, tx_submit, tx_complete, to_noc_prt_stat, rx_recieve, dat_from_noc, rx_complete, port_address, port_number).
REQ-012 tmo_err  out  1  sticky timeout flag (REQ-030 only; tied 0 otherwise).

Function
REQ-013 TX FSM states SHALL be TX_IDLE and TX_BUSY.
REQ-014 In TX_IDLE, if any req_submit set, SHALL grant one requester round-robin starting after the last granted index (index 0 first after reset) and enter TX_BUSY next cycle.
REQ-015 In TX_BUSY, SHALL drive noc_port.tx_submit=1 and dat_to_noc=req_pkt[grant], with src_addr/src_prt replaced by noc_port.port_address/port_number and id replaced by the grant index.
REQ-016 Grant SHALL be held unchanged until noc_port.tx_complete sampled high while to_noc_prt_stat==port_open; that cycle SHALL pulse req_tx_done[grant] and return to TX_IDLE.
REQ-017 Grant-to-grant turnaround SHALL be at least one TX_IDLE cycle; tx_submit SHALL be 0 in TX_IDLE.
REQ-018 Requester dropping req_submit while granted SHALL NOT cancel the transfer already presented.
REQ-019 RX FSM states SHALL be RX_IDLE and RX_DELIVER, independent of TX FSM.
REQ-020 In RX_IDLE with noc_port.rx_recieve=1, SHALL capture dat_from_noc into rsp_pkt and target = dat_from_noc.id, enter RX_DELIVER.
REQ-021 In RX_DELIVER, SHALL hold rsp_valid[target]=1 until rsp_done[target]; that cycle SHALL pulse noc_port.rx_complete for one cycle and return to RX_IDLE.
REQ-022 Reply with id >= NUM_REQ SHALL be dropped: rx_complete pulsed in the capture cycle, no rsp_valid, remain RX_IDLE.
REQ-023 Simultaneous tx_complete and rx_recieve SHALL both be serviced in the same cycle.
REQ-024 rsp_done for a non-target requester SHALL be ignored.

Reset
REQ-025 While rst high: TX_IDLE, RX_IDLE, round-robin pointer=0, tx_submit=0, rx_complete=0, req_tx_done=0, rsp_valid=0, rsp_pkt=0, tmo_err=0.
REQ-026 Reset mid-transfer SHALL abandon grant and held reply without pulsing req_tx_done or rx_complete.

Configuration
REQ-027 Macro NOC_ARB_TIMEOUT_EN SHALL select the grant timeout.
REQ-028 With it defined, an 8-bit counter SHALL count TX_BUSY cycles, cleared on entering TX_BUSY.
REQ-029 Counter reaching TMO_CYCLES without tx_complete SHALL drop tx_submit, return to TX_IDLE without req_tx_done, advance round-robin pointer.
REQ-030 Timeout SHALL set tmo_err, cleared only by rst.
REQ-031 Without it, no counter exists, grant is held indefinitely, tmo_err constant 0.

Structure
REQ-032 NOC_ARB_MAX_REQ=4 and the tx/rx state enums SHALL live in structs.sv beside packet and port-status types.
REQ-033 Round-robin selection SHALL be a sub-module rr_arbiter (request vector, pointer in; one-hot grant, index out; combinational).

Verification
REQ-034 Only req 1 submits memory_read_request, tx_complete 3 cycles later -> tx_submit for 3 cycles, dat_to_noc.id=1, req_tx_done[1] one pulse.
REQ-035 Reqs 0 and 1 submit together, held -> grant order 0,1,0,1 across four completions.
REQ-036 Reply id=0 arrives, rsp_done[0] asserted 5 cycles later -> rsp_valid[0] 5 cycles, rx_complete one pulse on 5th cycle.
REQ-037 Reply id=3 with NUM_REQ=2 -> rx_complete pulse same cycle, rsp_valid stays 0.
REQ-038 With NOC_ARB_TIMEOUT_EN, TMO_CYCLES=10, tx_complete never returned -> tx_submit drops after 10 cycles, tmo_err=1, next requester granted.
REQ-039 rst asserted during TX_BUSY and RX_DELIVER -> next cycle all outputs at REQ-025 values.
